status_irq_ctrl: RTL and testbench

Parametrised status and interrupt controller for the UART datapath, and the next generation of the fixed two-channel status block. It captures NUM_SRC live busy levels and sticky done flags. It adds a CPU-writable interrupt mask, write-1-to-clear of individual done flags, selectable edge or level capture, and an interrupt holdoff (coalescing) timer. It sits between the transmit/receive engines and the CPU register interface and drives the single UART interrupt line.

---
 rtl/status_irq_ctrl.sv | 147 ++++++++++++++
 tb/tb_status_irq_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/status_irq_ctrl.sv
// Status and interrupt controller: per-source busy/done capture, CPU mask and
// write-1-to-clear, and a holdoff timer that coalesces done events onto one IRQ.

module status_irq_flag #(
  parameter bit DONE_EDGE = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_done,
  input  logic i_w1c,
  output logic o_flag
);
  logic r_done_d;
  logic r_flag;
  logic w_set;

  assign w_set = DONE_EDGE ? (i_done & ~r_done_d) : i_done;

  // A set in the same cycle as a W1C wins so no completion is lost.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_done_d <= 1'b0;
      r_flag   <= 1'b0;
    end else begin
      r_done_d <= i_done;
      if (i_clear)     r_flag <= 1'b0;
      else if (w_set)  r_flag <= 1'b1;
      else if (i_w1c)  r_flag <= 1'b0;
    end
  end

  assign o_flag = r_flag;
endmodule

module status_irq_ctrl #(
  parameter int NUM_SRC   = 2,
  parameter int STATUS_W  = 8,
  parameter int HOLDOFF_W = 8,
  parameter int DONE_EDGE = 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_clear_flags,
  input  logic [NUM_SRC-1:0]  i_busy,
  input  logic [NUM_SRC-1:0]  i_done,
  input  logic                i_cfg_we,
  input  logic [1:0]          i_cfg_addr,
  input  logic [STATUS_W-1:0] i_cfg_wdata,
  output logic [STATUS_W-1:0] o_cfg_rdata,
  output logic [STATUS_W-1:0] o_status,
  output logic [NUM_SRC-1:0]  o_irq_src,
  output logic                o_int
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ASSERT} state_t;

  state_t               r_state, w_state_nxt;
  logic [HOLDOFF_W-1:0] r_cnt, w_cnt_nxt, r_holdoff;
  logic [NUM_SRC-1:0]   r_busy, r_mask, w_done, w_w1c;
  logic                 w_pending, r_int;

  assign w_w1c = (i_cfg_we && i_cfg_addr == 2'd0) ? i_cfg_wdata[2*NUM_SRC-1:NUM_SRC] : '0;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    status_irq_flag #(.DONE_EDGE(DONE_EDGE != 0)) u_flag (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_clear (i_clear_flags),
      .i_done  (i_done[g]),
      .i_w1c   (w_w1c[g]),
      .o_flag  (w_done[g])
    );
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_busy    <= '0;
      r_mask    <= '1;
      r_holdoff <= '0;
    end else begin
      r_busy <= i_clear_flags ? '0 : i_busy;
      if (i_cfg_we && i_cfg_addr == 2'd1) r_mask    <= i_cfg_wdata[NUM_SRC-1:0];
      if (i_cfg_we && i_cfg_addr == 2'd2) r_holdoff <= i_cfg_wdata[HOLDOFF_W-1:0];
    end
  end

  assign o_irq_src = w_done & r_mask;
  assign w_pending = |o_irq_src;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_int   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_int   <= (w_state_nxt == S_ASSERT);
    end
  end

  // cnt is loaded only on IDLE->WAIT, so holdoff writes during WAIT wait for the next run.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_pending) begin
          if (r_holdoff == '0) begin
            w_state_nxt = S_ASSERT;
          end else begin
            w_cnt_nxt   = r_holdoff;
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!w_pending)                    w_state_nxt = S_IDLE;
        else if (r_cnt == HOLDOFF_W'(1))   w_state_nxt = S_ASSERT;
        else                               w_cnt_nxt   = r_cnt - HOLDOFF_W'(1);
      end
      S_ASSERT: begin
        if (!w_pending) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (i_clear_flags) w_state_nxt = S_IDLE;
  end

  assign o_int = r_int;

  always_comb begin
    o_status                        = '0;
    o_status[NUM_SRC-1:0]           = r_busy;
    o_status[2*NUM_SRC-1:NUM_SRC]   = w_done;
  end

  always_comb begin
    o_cfg_rdata = '0;
    case (i_cfg_addr)
      2'd0:    o_cfg_rdata = o_status;
      2'd1:    o_cfg_rdata[NUM_SRC-1:0]   = r_mask;
      2'd2:    o_cfg_rdata[HOLDOFF_W-1:0] = r_holdoff;
      default: o_cfg_rdata = '0;
    endcase
  end
endmodule

// File: tb/tb_status_irq_ctrl.sv
// Bench for status_irq_ctrl: directed scenarios plus a randomized run against a
// rule-level model, with an edge-capture and a level-capture instance side by side.
module tb_status_irq_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clear = 1'b0;
  logic [1:0] busy = '0, done = '0, addr = '0;
  logic       we = 1'b0;
  logic [7:0] wdata = '0;
  logic [7:0] rdata_e, status_e, rdata_l, status_l;
  logic [1:0] irq_e, irq_l;
  logic       int_e, int_l;

  int checks = 0;
  int errors = 0;

  // rule-level model: index 0 = edge instance, 1 = level instance
  logic [1:0] m_done [2];
  int         m_run  [2];
  int         m_lat  [2];
  logic [1:0] m_busy, m_mask, m_dprev;
  logic [7:0] m_hold;

  status_irq_ctrl #(.NUM_SRC(2), .STATUS_W(8), .HOLDOFF_W(8), .DONE_EDGE(1)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_clear_flags(clear), .i_busy(busy), .i_done(done),
    .i_cfg_we(we), .i_cfg_addr(addr), .i_cfg_wdata(wdata),
    .o_cfg_rdata(rdata_e), .o_status(status_e), .o_irq_src(irq_e), .o_int(int_e));

  status_irq_ctrl #(.NUM_SRC(2), .STATUS_W(8), .HOLDOFF_W(8), .DONE_EDGE(0)) u_lvl (
    .i_clk(clk), .i_rst(rst), .i_clear_flags(clear), .i_busy(busy), .i_done(done),
    .i_cfg_we(we), .i_cfg_addr(addr), .i_cfg_wdata(wdata),
    .o_cfg_rdata(rdata_l), .o_status(status_l), .o_irq_src(irq_l), .o_int(int_l));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running exp finished");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
    we = 1'b1; addr = a; wdata = d;
    cyc();
    we = 1'b0; addr = 2'd0; wdata = '0;
  endtask

  // One clock of the model: an interrupt is raised once pending has been seen on
  // holdoff+1 consecutive edges, with holdoff taken at the first edge of the run.
  task automatic model_step();
    logic [1:0] set, w1c;
    w1c = (we && addr == 2'd0) ? wdata[3:2] : 2'b00;
    for (int e = 0; e < 2; e++) begin
      if (clear) m_run[e] = 0;
      else if (|(m_done[e] & m_mask)) begin
        if (m_run[e] == 0) m_lat[e] = int'(m_hold);
        if (m_run[e] < 100000) m_run[e]++;
      end else m_run[e] = 0;
      set = (e == 0) ? (done & ~m_dprev) : done;
      for (int b = 0; b < 2; b++)
        if (clear)       m_done[e][b] = 1'b0;
        else if (set[b]) m_done[e][b] = 1'b1;
        else if (w1c[b]) m_done[e][b] = 1'b0;
    end
    m_busy  = clear ? 2'b00 : busy;
    m_dprev = done;
    if (we && addr == 2'd1) m_mask = wdata[1:0];
    if (we && addr == 2'd2) m_hold = wdata;
  endtask

  task automatic test_reset();
    rst = 1'b0; busy = 2'b11; done = 2'b11;
    #23;
    addr = 2'd0; #1;
    checks++; if (status_e !== 8'h00) begin errors++; $display("FAIL reset_status got %h exp 00", status_e); end
    checks++; if (int_e !== 1'b0) begin errors++; $display("FAIL reset_int got %b exp 0", int_e); end
    checks++; if (irq_e !== 2'b00) begin errors++; $display("FAIL reset_irq_src got %b exp 00", irq_e); end
    addr = 2'd1; #1;
    checks++; if (rdata_e !== 8'h03) begin errors++; $display("FAIL reset_mask got %h exp 03", rdata_e); end
    addr = 2'd2; #1;
    checks++; if (rdata_e !== 8'h00) begin errors++; $display("FAIL reset_holdoff got %h exp 00", rdata_e); end
    addr = 2'd0; done = 2'b00;
    cyc();
    rst = 1'b1;
    cyc();
    checks++; if (status_e !== 8'h03) begin errors++; $display("FAIL busy_capture got %h exp 03", status_e); end
    busy = 2'b00;
    cyc();
  endtask

  task automatic test_basic_irq();
    done = 2'b01;
    cyc();
    done = 2'b00;
    checks++; if (status_e !== 8'h04) begin errors++; $display("FAIL basic_flag got %h exp 04", status_e); end
    checks++; if (int_e !== 1'b0) begin errors++; $display("FAIL basic_int_early got %b exp 0", int_e); end
    cyc();
    checks++; if (int_e !== 1'b1) begin errors++; $display("FAIL basic_int_rise got %b exp 1", int_e); end
    cfg_write(2'd0, 8'h04);
    checks++; if (status_e !== 8'h00) begin errors++; $display("FAIL basic_w1c got %h exp 00", status_e); end
    checks++; if (int_e !== 1'b1) begin errors++; $display("FAIL basic_int_hold got %b exp 1", int_e); end
    cyc();
    checks++; if (int_e !== 1'b0) begin errors++; $display("FAIL basic_int_fall got %b exp 0", int_e); end
  endtask

  task automatic test_coalesce();
    cfg_write(2'd2, 8'd5);
    addr = 2'd2; #1;
    checks++; if (rdata_e !== 8'h05) begin errors++; $display("FAIL holdoff_read got %h exp 05", rdata_e); end
    addr = 2'd0;
    done = 2'b10; cyc();          // edge k
    done = 2'b00; cyc();          // k+1
    done = 2'b01; cyc();          // k+2
    done = 2'b00;
    for (int i = 3; i <= 5; i++) begin
      cyc();
      checks++; if (int_e !== 1'b0) begin errors++; $display("FAIL coalesce_early k+%0d got %b exp 0", i, int_e); end
    end
    cyc();
    checks++; if (int_e !== 1'b1) begin errors++; $display("FAIL coalesce_rise got %b exp 1", int_e); end
    checks++; if (status_e !== 8'h0C) begin errors++; $display("FAIL coalesce_status got %h exp 0C", status_e); end
    cfg_write(2'd0, 8'h0C);
    cyc();
    cfg_write(2'd2, 8'd0);
    checks++; if (int_e !== 1'b0) begin errors++; $display("FAIL coalesce_clear got %b exp 0", int_e); end
  endtask

  task automatic test_mask();
    cfg_write(2'd1, 8'h01);
    done = 2'b10; cyc();
    done = 2'b00;
    checks++; if (status_e !== 8'h08) begin errors++; $display("FAIL mask_status got %h exp 08", status_e); end
    checks++; if (irq_e !== 2'b00) begin errors++; $display("FAIL mask_irq_src got %b exp 00", irq_e); end
    cyc(); cyc();
    checks++; if (int_e !== 1'b0) begin errors++; $display("FAIL mask_int got %b exp 0", int_e); end
    cfg_write(2'd1, 8'h03);
    checks++; if (irq_e !== 2'b10) begin errors++; $display("FAIL unmask_irq_src got %b exp 10", irq_e); end
    checks++; if (int_e !== 1'b0) begin errors++; $display("FAIL unmask_int_early got %b exp 0", int_e); end
    cyc();
    checks++; if (int_e !== 1'b1) begin errors++; $display("FAIL unmask_int got %b exp 1", int_e); end
    cfg_write(2'd0, 8'h08);
    cyc();
  endtask

  task automatic test_collision();
    done = 2'b01; we = 1'b1; addr = 2'd0; wdata = 8'h04;
    cyc();
    done = 2'b00; we = 1'b0; wdata = '0;
    checks++; if (status_e !== 8'h04) begin errors++; $display("FAIL set_beats_w1c got %h exp 04", status_e); end
    cyc();
    checks++; if (int_e !== 1'b1) begin errors++; $display("FAIL collision_int got %b exp 1", int_e); end
    done = 2'b10; clear = 1'b1; busy = 2'b11;
    cyc();
    checks++; if (status_e !== 8'h00) begin errors++; $display("FAIL clear_status got %h exp 00", status_e); end
    checks++; if (int_e !== 1'b0) begin errors++; $display("FAIL clear_int got %b exp 0", int_e); end
    done = 2'b00; clear = 1'b0; busy = 2'b00;
    cyc();
    checks++; if (int_e !== 1'b0) begin errors++; $display("FAIL clear_idle got %b exp 0", int_e); end
  endtask

  task automatic test_edge_level();
    clear = 1'b1; cyc(); clear = 1'b0;
    done = 2'b01;
    for (int c = 1; c <= 10; c++) begin
      we = (c == 3); addr = 2'd0; wdata = (c == 3) ? 8'h04 : 8'h00;
      cyc();
      checks++; if (status_e[2] !== (c < 3)) begin errors++; $display("FAIL edge_hold c%0d got %b exp %b", c, status_e[2], (c < 3)); end
      checks++; if (status_l[2] !== 1'b1) begin errors++; $display("FAIL level_hold c%0d got %b exp 1", c, status_l[2]); end
    end
    we = 1'b0; wdata = '0; done = 2'b00;
    clear = 1'b1; cyc(); clear = 1'b0;
  endtask

  task automatic test_async_reset();
    cfg_write(2'd2, 8'd5);
    done = 2'b01; cyc();
    done = 2'b00; cyc();
    checks++; if (u_dut.r_cnt !== 8'd5) begin errors++; $display("FAIL wait_cnt got %0d exp 5", u_dut.r_cnt); end
    addr = 2'd2;
    #2 rst = 1'b0; #1;
    checks++; if (int_e !== 1'b0) begin errors++; $display("FAIL async_int got %b exp 0", int_e); end
    checks++; if (u_dut.r_cnt !== 8'd0) begin errors++; $display("FAIL async_cnt got %0d exp 0", u_dut.r_cnt); end
    checks++; if (rdata_e !== 8'h00) begin errors++; $display("FAIL async_holdoff got %h exp 00", rdata_e); end
    checks++; if (status_e !== 8'h00) begin errors++; $display("FAIL async_status got %h exp 00", status_e); end
    addr = 2'd0;
    cyc(); rst = 1'b1; cyc();
    done = 2'b01; cyc();
    done = 2'b00; cyc();
    checks++; if (int_e !== 1'b1) begin errors++; $display("FAIL pre_reset_int got %b exp 1", int_e); end
    #2 rst = 1'b0; #1;
    checks++; if (int_e !== 1'b0) begin errors++; $display("FAIL async_int_assert got %b exp 0", int_e); end
    cyc(); rst = 1'b1; cyc();
  endtask

  task automatic test_random();
    logic [7:0] exp_st, exp_rd;
    logic [7:0] got_st [2];
    logic [7:0] got_rd [2];
    logic [1:0] got_irq [2];
    logic       got_int [2];
    rst = 1'b0; clear = 1'b0; busy = '0; done = '0; we = 1'b0; addr = '0; wdata = '0;
    cyc(); rst = 1'b1;
    for (int e = 0; e < 2; e++) begin m_done[e] = '0; m_run[e] = 0; m_lat[e] = 0; end
    m_busy = '0; m_mask = 2'b11; m_dprev = '0; m_hold = '0;
    for (int n = 0; n < 600; n++) begin
      clear = ($urandom_range(0, 24) == 0);
      busy  = 2'($urandom);
      done  = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
      we    = ($urandom_range(0, 3) == 0);
      addr  = 2'($urandom);
      wdata = (addr == 2'd2) ? 8'($urandom_range(0, 4)) : 8'($urandom);
      model_step();
      cyc();
      got_st[0] = status_e; got_st[1] = status_l;
      got_rd[0] = rdata_e;  got_rd[1] = rdata_l;
      got_irq[0] = irq_e;   got_irq[1] = irq_l;
      got_int[0] = int_e;   got_int[1] = int_l;
      for (int e = 0; e < 2; e++) begin
        exp_st = {4'h0, m_done[e], m_busy};
        case (addr)
          2'd0:    exp_rd = exp_st;
          2'd1:    exp_rd = {6'h0, m_mask};
          2'd2:    exp_rd = m_hold;
          default: exp_rd = 8'h00;
        endcase
        checks++; if (got_st[e] !== exp_st) begin errors++; $display("FAIL rnd_status i%0d n%0d got %h exp %h", e, n, got_st[e], exp_st); end
        checks++; if (got_irq[e] !== (m_done[e] & m_mask)) begin errors++; $display("FAIL rnd_irq_src i%0d n%0d got %b exp %b", e, n, got_irq[e], m_done[e] & m_mask); end
        checks++; if (got_int[e] !== (m_run[e] > m_lat[e])) begin errors++; $display("FAIL rnd_int i%0d n%0d got %b exp %b", e, n, got_int[e], (m_run[e] > m_lat[e])); end
        checks++; if (got_rd[e] !== exp_rd) begin errors++; $display("FAIL rnd_rdata i%0d n%0d got %h exp %h", e, n, got_rd[e], exp_rd); end
      end
    end
    clear = 1'b0; we = 1'b0; done = '0; busy = '0;
  endtask

  initial begin
    test_reset();
    test_basic_irq();
    test_coalesce();
    test_mask();
    test_collision();
    test_edge_level();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
